// File: rtl/alu_seq.sv
// Multi-cycle ALU: one-cycle ops, 32-step shift-add multiply, optional divide.
// Define ALU_SEQ_DIV_EN to build the 32-step restoring divider for opcode 9.
module alu_seq (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [3:0]  rd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        wb_load,
  output logic [3:0]  wb_rop,
  output logic [31:0] wb_data,
  output logic [3:0]  flags,
  output logic        err
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SAR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

`ifdef ALU_SEQ_DIV_EN
  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUL, S_DIV, S_WB
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUL, S_WB
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        load_q, load_d;
  logic        err_q, err_d;
  logic [3:0]  rop_q, rop_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  flags_q, flags_d;

  logic [4:0]  sh;
  logic [32:0] add_w, sub_w, shl_w, shr_w;
  logic signed [32:0] sar_w;
  logic [32:0] mul_sum;
  logic [31:0] res;
  logic        res_c, res_v, res_err;

  assign sh      = b_q[4:0];
  assign add_w   = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w   = {1'b0, a_q} - {1'b0, b_q};
  assign shl_w   = {1'b0, a_q} << sh;
  assign shr_w   = {a_q, 1'b0} >> sh;
  assign sar_w   = $signed({a_q, 1'b0}) >>> sh;
  assign mul_sum = {1'b0, prod_q[63:32]}
                 + (prod_q[0] ? {1'b0, a_q} : 33'd0);

`ifdef ALU_SEQ_DIV_EN
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic        div_ge;
  assign div_sh   = {prod_q[63:32], prod_q[31]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = div_sh >= {1'b0, b_q};
`endif

  // Result selection; only consumed in WB.
  always_comb begin
    res     = 32'd0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    unique case (1'b1)
      op_q == OP_ADD: begin
        res   = add_w[31:0];
        res_c = add_w[32];
        res_v = (a_q[31] == b_q[31]) && (res[31] != a_q[31]);
      end
      op_q == OP_SUB: begin
        res   = sub_w[31:0];
        res_c = ~sub_w[32];
        res_v = (a_q[31] != b_q[31]) && (res[31] != a_q[31]);
      end
      op_q == OP_AND: res = a_q & b_q;
      op_q == OP_OR:  res = a_q | b_q;
      op_q == OP_XOR: res = a_q ^ b_q;
      op_q == OP_SHL: begin
        res   = shl_w[31:0];
        res_c = shl_w[32];
      end
      op_q == OP_SHR: begin
        res   = shr_w[32:1];
        res_c = shr_w[0];
      end
      op_q == OP_SAR: begin
        res   = sar_w[32:1];
        res_c = sar_w[0];
      end
      op_q == OP_MUL: begin
        res   = prod_q[31:0];
        res_c = |prod_q[63:32];
        res_v = |prod_q[63:32];
      end
`ifdef ALU_SEQ_DIV_EN
      op_q == OP_DIV: begin
        res     = prod_q[31:0];
        res_err = b_q == 32'd0;
      end
`endif
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load_d  = 1'b0;
    err_d   = 1'b0;
    rop_d   = rop_q;
    data_d  = data_q;
    flags_d = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = opcode;
          rd_d   = rd;
          a_d    = op_a;
          b_d    = op_b;
          cnt_d  = 5'd0;
          prod_d = {32'd0, (opcode == OP_DIV) ? op_a : op_b};
          if (opcode == OP_MUL) begin
            state_d = S_MUL;
`ifdef ALU_SEQ_DIV_EN
          end else if (opcode == OP_DIV) begin
            state_d = S_DIV;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: state_d = S_WB;
      S_MUL: begin
        prod_d = {mul_sum, prod_q[31:1]};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_WB;
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        prod_d = {div_ge ? div_diff[31:0] : div_sh[31:0],
                  prod_q[30:0], div_ge};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_WB;
      end
`endif
      S_WB: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = res_err;
        load_d  = ~res_err;
        rop_d   = rd_q;
        // Illegal opcodes write zero; divide-by-zero keeps the all-ones quotient.
        data_d  = (res_err && op_q != OP_DIV) ? 32'd0 : res;
        if (!res_err) flags_d = {res[31], res == 32'd0, res_c, res_v};
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      rd_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      prod_q  <= 64'd0;
      cnt_q   <= 5'd0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      rop_q   <= 4'd0;
      data_q  <= 32'd0;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      load_q  <= load_d;
      err_q   <= err_d;
      rop_q   <= rop_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign busy    = state_q != S_IDLE;
  assign done    = done_q;
  assign wb_load = load_q;
  assign err     = err_q;
  assign wb_rop  = rop_q;
  assign wb_data = data_q;
  assign flags   = flags_q;

endmodule
